// File: rtl/reg_bank_operands.sv
// Purpose : 32 x XLEN integer register bank (x0 hardwired to zero) with registered A/B operand latches.
// Latency : writes visible on DBG_DATA one cycle later; A/B operands one cycle after LOAD_AB, with write-first bypass.
// Backpressure: none; the control FSM holds inputs stable around edges where REG_WRITE/LOAD_AB are asserted.
//
// Ports:
//   CLK        rising-edge clock for all state
//   RST        asynchronous active-low reset; clears x1..x31, A_OUT and B_OUT
//   RS1/RS2    source indices (instruction bits 19:15 / 24:20)
//   RD         destination index (instruction bits 11:7)
//   WR_DATA    write-back data, stored when REG_WRITE=1 and RD!=0
//   REG_WRITE  write enable for RD
//   LOAD_AB    capture srcval(RS1)/srcval(RS2) into A_OUT/B_OUT
//   A_OUT      latched operand A
//   B_OUT      latched operand B
//   DBG_ADDR   debug read index
//   DBG_DATA   combinational read of the stored value at DBG_ADDR (no bypass)

module reg_bank_operands #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [AW-1:0]   RS1,
   input  logic [AW-1:0]   RS2,
   input  logic [AW-1:0]   RD,
   input  logic [XLEN-1:0] WR_DATA,
   input  logic            REG_WRITE,
   input  logic            LOAD_AB,
   output logic [XLEN-1:0] A_OUT,
   output logic [XLEN-1:0] B_OUT,
   input  logic [AW-1:0]   DBG_ADDR,
   output logic [XLEN-1:0] DBG_DATA
);

   // Physical storage exists only for x1..x31; x0 is synthesised as a constant.
   logic [XLEN-1:0] r_regs [1:NREGS-1];
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;

   // Full architectural view including the constant-zero x0, used by all read muxes.
   logic [XLEN-1:0] w_view [0:NREGS-1];
   logic            w_wr_en;
   logic [XLEN-1:0] w_src1;
   logic [XLEN-1:0] w_src2;

   // A write to x0 is dropped here so no downstream logic needs to special-case it.
   assign w_wr_en = REG_WRITE && (RD != '0);

   always_comb begin
      w_view[0] = '0;
      for (int i = 1; i < NREGS; i++) begin
         w_view[i] = r_regs[i];
      end
   end

   // Operand source selection: x0 forces zero, then a same-cycle write to the
   // same index wins over the stored value (write-first bypass).
   always_comb begin
      w_src1 = w_view[RS1];
      if (RS1 == '0) begin
         w_src1 = '0;
      end else if (w_wr_en && (RD == RS1)) begin
         w_src1 = WR_DATA;
      end
   end

   always_comb begin
      w_src2 = w_view[RS2];
      if (RS2 == '0) begin
         w_src2 = '0;
      end else if (w_wr_en && (RD == RS2)) begin
         w_src2 = WR_DATA;
      end
   end

   // Register file write port.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 1; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (w_wr_en && (RD == AW'(i))) begin
               r_regs[i] <= WR_DATA;
            end
         end
      end
   end

   // Operand latches: enable flops that hold whenever LOAD_AB is low.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_a <= '0;
         r_b <= '0;
      end else if (LOAD_AB) begin
         r_a <= w_src1;
         r_b <= w_src2;
      end
   end

   assign A_OUT    = r_a;
   assign B_OUT    = r_b;
   // Debug path reads storage only, so a pending write shows up one cycle later.
   assign DBG_DATA = w_view[DBG_ADDR];

endmodule

// File: tb/tb_reg_bank_operands.sv
// Purpose : self-checking bench for reg_bank_operands (vector table, directed corner sequences, random vs model).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next edge.
// Backpressure: none in the DUT; the bench runs a fixed number of cycles.

module tb_reg_bank_operands;

   logic        CLK;
   logic        RST;
   logic [4:0]  RS1;
   logic [4:0]  RS2;
   logic [4:0]  RD;
   logic [63:0] WR_DATA;
   logic        REG_WRITE;
   logic        LOAD_AB;
   logic [63:0] A_OUT;
   logic [63:0] B_OUT;
   logic [4:0]  DBG_ADDR;
   logic [63:0] DBG_DATA;

   int checks = 0;
   int errors = 0;

   // Behavioural model: architectural register array and the two operand latches.
   logic [63:0] m_regs [0:31];
   logic [63:0] m_a;
   logic [63:0] m_b;

   reg_bank_operands #(.XLEN(64), .NREGS(32), .AW(5)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RS1       (RS1),
      .RS2       (RS2),
      .RD        (RD),
      .WR_DATA   (WR_DATA),
      .REG_WRITE (REG_WRITE),
      .LOAD_AB   (LOAD_AB),
      .A_OUT     (A_OUT),
      .B_OUT     (B_OUT),
      .DBG_ADDR  (DBG_ADDR),
      .DBG_DATA  (DBG_DATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] src(input logic [4:0] idx);
      if (idx == 5'd0) return 64'h0;
      if (REG_WRITE && RD == idx) return WR_DATA;
      return m_regs[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 64'h0;
      m_a = 64'h0;
      m_b = 64'h0;
   endtask

   // One clock: model evaluates from the pre-edge inputs, committed only if reset is released.
   task automatic tick();
      logic [63:0] na, nb;
      na = m_a;
      nb = m_b;
      if (LOAD_AB) begin
         na = src(RS1);
         nb = src(RS2);
      end
      @(posedge CLK);
      if (RST) begin
         m_a = na;
         m_b = nb;
         if (REG_WRITE && RD != 5'd0) m_regs[RD] = WR_DATA;
      end
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [63:0] wd,
                        input logic ld, input logic [4:0] rs1, input logic [4:0] rs2);
      REG_WRITE = we;
      RD        = rd;
      WR_DATA   = wd;
      LOAD_AB   = ld;
      RS1       = rs1;
      RS2       = rs2;
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [63:0] wd;
      logic        ld;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  dbg;
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] ed;
   } vec_t;

   vec_t vt [7];

   initial begin
      logic [63:0] exp_v;

      // Directed vectors, applied in order from a freshly reset bank.
      vt[0] = '{1'b1, 5'd7, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0, 5'd0, 5'd7,
                64'h0, 64'h0, 64'h0123_4567_89AB_CDEF};
      vt[1] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd0, 5'd7,
                64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF};
      vt[2] = '{1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0,
                64'h0123_4567_89AB_CDEF, 64'h0, 64'h0};
      vt[3] = '{1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0,
                64'h0, 64'h0, 64'h0};
      vt[4] = '{1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 5'd0, 5'd3,
                64'h0, 64'h0, 64'h11};
      vt[5] = '{1'b1, 5'd3, 64'h22, 1'b1, 5'd3, 5'd3, 5'd3,
                64'h22, 64'h22, 64'h22};
      vt[6] = '{1'b1, 5'd9, 64'h5555, 1'b1, 5'd3, 5'd9, 5'd9,
                64'h22, 64'h5555, 64'h5555};

      // ---------------- reset state ----------------
      RST = 1'b0;
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0);
      DBG_ADDR = 5'd0;
      model_reset();
      @(posedge CLK);
      #1;
      chk("reset_a", A_OUT, 64'h0);
      chk("reset_b", B_OUT, 64'h0);
      @(posedge CLK);
      #1;
      for (int i = 0; i < 32; i += 5) begin
         DBG_ADDR = 5'(i);
         #1;
         chk("reset_dbg", DBG_DATA, 64'h0);
      end
      RST = 1'b1;

      // ---------------- table-driven vectors ----------------
      for (int v = 0; v < 7; v++) begin
         drive(vt[v].we, vt[v].rd, vt[v].wd, vt[v].ld, vt[v].rs1, vt[v].rs2);
         DBG_ADDR = vt[v].dbg;
         #1;
         // Debug read must still show the stored value while a write is pending.
         chk("tbl_dbg_pre", DBG_DATA, m_regs[vt[v].dbg]);
         tick();
         chk("tbl_a", A_OUT, vt[v].ea);
         chk("tbl_b", B_OUT, vt[v].eb);
         chk("tbl_dbg", DBG_DATA, vt[v].ed);
      end

      // Bypass corner: new write pending, debug shows old value, operands take the new one.
      drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd3, 5'd0);
      DBG_ADDR = 5'd3;
      #1;
      chk("byp_dbg_old", DBG_DATA, 64'h22);
      tick();
      chk("byp_a_new", A_OUT, 64'h33);
      chk("byp_b_x0", B_OUT, 64'h0);
      chk("byp_dbg_new", DBG_DATA, 64'h33);

      // ---------------- hold behaviour ----------------
      drive(1'b1, 5'd1, 64'hA, 1'b0, 5'd0, 5'd0);
      tick();
      drive(1'b1, 5'd2, 64'hB, 1'b0, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd1, 5'd2);
      tick();
      chk("hold_load_a", A_OUT, 64'hA);
      chk("hold_load_b", B_OUT, 64'hB);
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), {$urandom, $urandom}, 1'b0, 5'(i), 5'(32 - i));
         tick();
         chk("hold_a", A_OUT, 64'hA);
         chk("hold_b", B_OUT, 64'hB);
      end

      // ---------------- sweep with no aliasing ----------------
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 64'(i) * 64'h0101, 1'b0, 5'd0, 5'd0);
         tick();
      end
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         DBG_ADDR = 5'(i);
         #1;
         exp_v = 64'(i) * 64'h0101;
         chk("sweep_dbg", DBG_DATA, exp_v);
      end

      // ---------------- random stimulus vs model ----------------
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         // Bias toward the bypass and x0 corners.
         if ($urandom_range(0, 3) == 0) RS1 = RD;
         if ($urandom_range(0, 3) == 0) RS2 = RD;
         if ($urandom_range(0, 7) == 0) RD = 5'd0;
         DBG_ADDR = 5'($urandom_range(0, 31));
         #1;
         chk("rnd_dbg", DBG_DATA, m_regs[DBG_ADDR]);
         tick();
         chk("rnd_a", A_OUT, m_a);
         chk("rnd_b", B_OUT, m_b);
      end

      // ---------------- mid-run asynchronous reset ----------------
      drive(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
      tick();
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd5);
      DBG_ADDR = 5'd5;
      tick();
      chk("mr_pre_a", A_OUT, 64'hDEAD_BEEF);
      chk("mr_pre_dbg", DBG_DATA, 64'hDEAD_BEEF);
      // Pending write and load are present when reset hits between edges.
      drive(1'b1, 5'd5, 64'h1234_5678, 1'b1, 5'd5, 5'd5);
      #2;
      RST = 1'b0;
      model_reset();
      #1;
      chk("mr_async_a", A_OUT, 64'h0);
      chk("mr_async_b", B_OUT, 64'h0);
      chk("mr_async_dbg", DBG_DATA, 64'h0);
      tick();
      tick();
      chk("mr_held_a", A_OUT, 64'h0);
      chk("mr_held_dbg", DBG_DATA, 64'h0);
      RST = 1'b1;
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd5);
      tick();
      chk("mr_post_a", A_OUT, 64'h0);
      chk("mr_post_b", B_OUT, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
